// File: rtl/y_compare_misr.sv
// Compares a reference and a synthesized output stream sample by sample.
// It counts mismatches, captures the first one, and compresses each stream into a 32-bit MISR signature.

module y_compare_misr_lane #(
    parameter int          WIDTH = 82,
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] y,
    output logic [31:0]      sig,
    output logic [31:0]      sig_nxt
);
    localparam int CH = (WIDTH + 31) / 32;

    logic [CH*32-1:0] pad;
    logic [31:0]      fold;

    // XOR of all 32-bit chunks; the top chunk is zero-padded.
    always_comb begin
        pad = '0;
        pad[WIDTH-1:0] = y;
        fold = '0;
        for (int i = 0; i < CH; i++)
            fold = fold ^ pad[i*32 +: 32];
    end

    always_comb begin
        sig_nxt = sig;
        if (load)
            sig_nxt = SEED;
        else if (en)
            sig_nxt = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ fold;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig <= SEED;
        else        sig <= sig_nxt;
    end
endmodule

module y_compare_misr #(
    parameter int          WIDTH   = 82,
    parameter int          NUM_VEC = 22,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] SEED    = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] y_ref,
    input  logic [WIDTH-1:0] y_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      sample_count,
    output logic [15:0]      mismatch_count,
    output logic [15:0]      first_idx,
    output logic [WIDTH-1:0] first_xor,
    output logic [31:0]      sig_ref,
    output logic [31:0]      sig_dut
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] LAST = 16'(NUM_VEC - 1);

    state_t                   state, state_n;
    logic                     load, acc, neq;
    logic [15:0]              mm_n;
    logic [1:0][WIDTH-1:0]    y_pair;
    logic [1:0][31:0]         sig_q, sig_n;

    assign neq    = (y_ref != y_dut);
    assign y_pair = {y_dut, y_ref};

    // Lane 0 is the reference stream, lane 1 the synthesized one.
    for (genvar l = 0; l < 2; l++) begin : g_lane
        y_compare_misr_lane #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load),
            .en      (acc),
            .y       (y_pair[l]),
            .sig     (sig_q[l]),
            .sig_nxt (sig_n[l])
        );
    end

    assign sig_ref = sig_q[0];
    assign sig_dut = sig_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        acc     = 1'b0;
        mm_n    = mismatch_count;
        case (state)
            IDLE, DONE: begin
                // A start wins over a coincident sample, which is dropped.
                if (start) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (sample_valid) begin
                    acc = 1'b1;
                    if (sample_count == LAST) state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load)
            mm_n = '0;
        else if (acc && neq && mismatch_count != 16'hFFFF)
            mm_n = mismatch_count + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            sample_count   <= '0;
            mismatch_count <= '0;
            first_idx      <= '0;
            first_xor      <= '0;
        end else begin
            busy           <= (state_n == RUN);
            done           <= (state_n == DONE);
            pass           <= (state_n == DONE) && (mm_n == 16'd0) && (sig_n[0] == sig_n[1]);
            mismatch_count <= mm_n;
            if (load) begin
                sample_count <= '0;
                first_idx    <= '0;
                first_xor    <= '0;
            end else if (acc) begin
                sample_count <= sample_count + 16'd1;
                if (neq && mismatch_count == 16'd0) begin
                    first_idx <= sample_count;
                    first_xor <= y_ref ^ y_dut;
                end
            end
        end
    end
endmodule
